i2s_rcvr: RTL and testbench
===========================

// Module: i2s_rcvr
// PURPOSE
//  I2S serial receiver; the receive-side counterpart of the I2S transmitter path.
//  Oversamples external SCK/WS/SD in the system clock domain and deserialises MSB-first I2S frames.
//  Delivers left (WS=0) and right (WS=1) words, with a valid pulse after each complete stereo frame.
//  Sits between the codec pins and the sample buffer/FIFO feeding the DSP datapath.
// PARAMETERS
//  WORD_W  16  bits captured per channel; data_left/data_right width
//  CNT_W   6   bit-counter width; must hold the longest slot (max 63 bits/channel)
// PORTS
//  clk         in   1       system clock; frequency must be >= 4x SCK
//  rst         in   1       reset; one clock; reset is asynchronous and active-high
//  sck         in   1       I2S bit clock, asynchronous to clk
//  ws          in   1       I2S word select: 0 = left, 1 = right
//  sd          in   1       I2S serial data, MSB first, one SCK after the WS edge
//  data_left   out  WORD_W  last complete left word, registered
//  data_right  out  WORD_W  last complete right word, registered
//  data_valid  out  1       1-clk pulse when a left+right pair has been updated
//  frame_err   out  1       sticky framing error; exists only with I2S_RCVR_FRAME_ERR_EN
// BEHAVIOUR
//  - Reset: all outputs 0, synchronisers 0, FSM=IDLE, bit_cnt=0, shift reg 0.
//  - Sync: sck/ws/sd each pass through 2 FFs; sck_rise = sck_s & ~sck_s_d (1-clk pulse).
//  - All protocol actions occur only in clk cycles with sck_rise=1; other cycles hold state.
//  - ws_chg = (ws_s != ws_last) on sck_rise; ws_last updates on every sck_rise.
//  - On a ws_chg rise, the sd bit sampled is the LSB of the OLD channel (ws_last).
//  - FSM IDLE: sample and discard bits; on the first ws_chg -> ACTIVE, bit_cnt=0 (partial word dropped).
//  - FSM ACTIVE, each sck_rise: if bit_cnt < WORD_W, shift sd in at the LSB; bit_cnt saturates at max.
//  - Bits beyond WORD_W in a slot are ignored (MSB-justified truncation).
//  - Short slots (< WORD_W bits): the word is left-aligned; missing LSBs are 0.
//  - On a ws_chg rise in ACTIVE: the word, including the current bit if bit_cnt < WORD_W,
//    goes to data_left (ws_last=0) or data_right (ws_last=1); shift reg and bit_cnt clear.
//  - data_valid: asserted the clk cycle after a ws_chg rise that closes a RIGHT word.
//    Latency sd-pin -> data_valid is 3-4 clk after the SCK edge plus the synchroniser.
//  - No backpressure; the consumer must take each pair before the next data_valid.
//  - The first data_valid after IDLE requires one complete left word then one complete right word;
//    a right word closed without a preceding left word in ACTIVE does not assert data_valid.
//  - rst mid-frame: immediate async clear, return to IDLE; the next WS edge resynchronises.
//  - SCK stopped: outputs hold indefinitely; no timeout.
// CONFIGURATION
//  I2S_RCVR_FRAME_ERR_EN defined:
//    - frame_err port present.
//    - Set when a ws_chg closes a slot with bit count != WORD_W; in IDLE, never set.
//    - Cleared only by rst. data_left/data_right are still updated on error.
//  I2S_RCVR_FRAME_ERR_EN undefined: frame_err port and its logic absent; slot length is unchecked.
// STRUCTURE
//  - i2s_pkg: typedef enum logic {IDLE, ACTIVE} i2s_rx_state_t; localparam I2S_WORD_W = 16.
//  - Sub-module flex_stp_sr #(WORD_W): serial-to-parallel shift register with shift_enable,
//    clear and serial_in; mirrors flex_pts_sr on the transmit side.
//  - Top level holds the synchronisers, edge detect, FSM, bit counter and output registers.
// TESTING
//  1. Reset: rst=1 mid-stream -> all outputs 0 and FSM IDLE; no data_valid until a full L+R pair.
//  2. Nominal: 16-bit slots, L=16'hA5C3 and R=16'h1234, clk=8x SCK
//     -> data_left=A5C3 and data_right=1234 with one data_valid pulse per frame.
//  3. Startup mid-word: start in the middle of a right slot
//     -> partial word discarded; first data_valid carries the next full L/R pair only.
//  4. 32-bit slots, L=32'hDEADBEEF -> data_left=16'hDEAD; with _EN, frame_err=1.
//  5. 12-bit slots, R=12'hABC -> data_right=16'hABC0; with _EN, frame_err=1 and stays 1 until rst.
//  6. Back-to-back frames at clk=4x SCK with random data -> scoreboard match and no dropped data_valid.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
// Optional framing check is enabled by defining I2S_RCVR_FRAME_ERR_EN.
package i2s_pkg;

    localparam int I2S_WORD_W = 16;
    localparam int I2S_CNT_W  = 6;

    typedef enum logic {
        IDLE,
        ACTIVE
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rcvr_if.sv
// Pin-side and word-side bundle of the I2S receiver.
// frame_err exists only when I2S_RCVR_FRAME_ERR_EN is defined.
interface i2s_rcvr_if #(
    parameter int WORD_W = i2s_pkg::I2S_WORD_W
);

    logic              sck;
    logic              ws;
    logic              sd;
    logic [WORD_W-1:0] data_left;
    logic [WORD_W-1:0] data_right;
    logic              data_valid;
`ifdef I2S_RCVR_FRAME_ERR_EN
    logic              frame_err;
`endif

    modport master (
        output sck, ws, sd,
`ifdef I2S_RCVR_FRAME_ERR_EN
        input  frame_err,
`endif
        input  data_left, data_right, data_valid
    );

    modport slave (
        input  sck, ws, sd,
`ifdef I2S_RCVR_FRAME_ERR_EN
        output frame_err,
`endif
        output data_left, data_right, data_valid
    );

endinterface

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register, MSB first, new bits enter at the LSB.
// Receive-side mirror of flex_pts_sr.
module flex_stp_sr
    import i2s_pkg::*;
#(
    parameter int WORD_W = I2S_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_enable,
    input  logic              clear,
    input  logic              serial_in,
    output logic [WORD_W-1:0] parallel_out
);

    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (shift_enable) begin
            sr_d = {sr_q[WORD_W-2:0], serial_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;

endmodule

// File: rtl/i2s_rcvr.sv
// I2S receiver: oversampled SCK/WS/SD, MSB-first stereo deserialiser.
// Define I2S_RCVR_FRAME_ERR_EN to add the sticky frame_err slot-length check.
module i2s_rcvr
    import i2s_pkg::*;
#(
    parameter int WORD_W = I2S_WORD_W,
    parameter int CNT_W  = I2S_CNT_W
) (
    input logic         clk,
    input logic         rst,
    i2s_rcvr_if.slave   bus
);

    logic          sck_meta_q, sck_s_q, sck_dly_q;
    logic          ws_meta_q, ws_s_q;
    logic          sd_meta_q, sd_s_q;

    i2s_rx_state_t state_q, state_d;
    logic          ws_last_q, ws_last_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] left_q, left_d;
    logic [WORD_W-1:0] right_q, right_d;
    logic          valid_q, valid_d;
    logic          have_left_q, have_left_d;
    logic          ferr_q, ferr_d;

    logic              sck_rise;
    logic              ws_chg;
    logic              cnt_lt;
    logic              shift_en;
    logic [WORD_W-1:0] sr_out;
    logic [WORD_W-1:0] word_ext;
    logic [CNT_W-1:0]  shamt;
    logic [WORD_W-1:0] closed_word;

    flex_stp_sr #(
        .WORD_W(WORD_W)
    ) u_sr (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (shift_en),
        .clear        (ws_chg),
        .serial_in    (sd_s_q),
        .parallel_out (sr_out)
    );

    always_comb begin
        sck_rise = sck_s_q & ~sck_dly_q;
        ws_chg   = sck_rise & (ws_s_q != ws_last_q);
        cnt_lt   = bit_cnt_q < CNT_W'(WORD_W);
        shift_en = sck_rise & ~ws_chg & cnt_lt & (state_q == ACTIVE);
        // Closing bit is appended, then short slots are left-aligned
        word_ext    = {sr_out[WORD_W-2:0], sd_s_q};
        shamt       = CNT_W'(WORD_W - 1) - bit_cnt_q;
        closed_word = cnt_lt ? (word_ext << shamt) : sr_out;
    end

    always_comb begin
        state_d     = state_q;
        ws_last_d   = ws_last_q;
        bit_cnt_d   = bit_cnt_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        have_left_d = have_left_q;
        ferr_d      = ferr_q;
        if (sck_rise) begin
            ws_last_d = ws_s_q;
            unique case (state_q)
                IDLE: begin
                    if (ws_chg) begin
                        state_d     = ACTIVE;
                        bit_cnt_d   = '0;
                        have_left_d = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ws_chg) begin
                        bit_cnt_d = '0;
                        if (ws_last_q) begin
                            right_d     = closed_word;
                            valid_d     = have_left_q;
                            have_left_d = 1'b0;
                        end else begin
                            left_d      = closed_word;
                            have_left_d = 1'b1;
                        end
                        if (bit_cnt_q != CNT_W'(WORD_W - 1)) begin
                            ferr_d = 1'b1;
                        end
                    end else if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta_q  <= 1'b0;
            sck_s_q     <= 1'b0;
            sck_dly_q   <= 1'b0;
            ws_meta_q   <= 1'b0;
            ws_s_q      <= 1'b0;
            sd_meta_q   <= 1'b0;
            sd_s_q      <= 1'b0;
            state_q     <= IDLE;
            ws_last_q   <= 1'b0;
            bit_cnt_q   <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            have_left_q <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sck_meta_q  <= bus.sck;
            sck_s_q     <= sck_meta_q;
            sck_dly_q   <= sck_s_q;
            ws_meta_q   <= bus.ws;
            ws_s_q      <= ws_meta_q;
            sd_meta_q   <= bus.sd;
            sd_s_q      <= sd_meta_q;
            state_q     <= state_d;
            ws_last_q   <= ws_last_d;
            bit_cnt_q   <= bit_cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            have_left_q <= have_left_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.data_left  = left_q;
    assign bus.data_right = right_q;
    assign bus.data_valid = valid_q;

`ifdef I2S_RCVR_FRAME_ERR_EN
    assign bus.frame_err = ferr_q;
`else
    logic unused_ferr;
    assign unused_ferr = ferr_q;
`endif

endmodule

// File: tb/tb_i2s_rcvr.sv
// Bench for i2s_rcvr: slot-level stream builder plus a run-based reference model.
// Covers frame_err checks when I2S_RCVR_FRAME_ERR_EN is defined.
module tb_i2s_rcvr;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    i2s_rcvr_if #(.WORD_W(W)) bus ();

    i2s_rcvr #(
        .WORD_W(W),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit         ws_q[$];
    bit         sd_q[$];
    logic [W-1:0] exp_l_q[$];
    logic [W-1:0] exp_r_q[$];
    logic [W-1:0] exp_left;
    logic [W-1:0] exp_right;
    bit         exp_ferr;
    int         exp_nv;
    int         n_valid;
    bit         mon_en = 1'b0;
    bit         dv_prev = 1'b0;

    task automatic new_stream();
        ws_q.delete();
        sd_q.delete();
        sd_q.push_back(1'b0);
    endtask

    // A slot's WS level starts with it; its data lags one SCK behind
    task automatic add_slot(input bit ch, input int len, input logic [63:0] val);
        for (int k = 0; k < len; k++) begin
            ws_q.push_back(ch);
            sd_q.push_back(val[len-1-k]);
        end
    endtask

    task automatic end_stream();
        bit last;
        last = ws_q[ws_q.size()-1];
        add_slot(~last, 1, 64'd0);
    endtask

    task automatic add_frames(input int n, input int len);
        for (int f = 0; f < n; f++) begin
            add_slot(1'b0, len, {$urandom, $urandom});
            add_slot(1'b1, len, {$urandom, $urandom});
        end
    endtask

    // Runs of constant WS after the first change are complete slots
    task automatic run_model();
        bit prev;
        bit act;
        bit hl;
        int st;
        int n;
        logic [W-1:0] w;
        prev = 1'b0;
        act  = 1'b0;
        hl   = 1'b0;
        st   = 0;
        exp_l_q.delete();
        exp_r_q.delete();
        exp_left  = '0;
        exp_right = '0;
        exp_ferr  = 1'b0;
        exp_nv    = 0;
        for (int i = 0; i < ws_q.size(); i++) begin
            if (ws_q[i] != prev) begin
                if (act) begin
                    n = i - st;
                    w = '0;
                    for (int k = 0; k < W && k < n; k++) begin
                        w[W-1-k] = sd_q[st+1+k];
                    end
                    if (n != W) exp_ferr = 1'b1;
                    if (ws_q[st]) begin
                        exp_right = w;
                        if (hl) begin
                            exp_l_q.push_back(exp_left);
                            exp_r_q.push_back(w);
                            exp_nv++;
                        end
                        hl = 1'b0;
                    end else begin
                        exp_left = w;
                        hl = 1'b1;
                    end
                end else begin
                    act = 1'b1;
                    hl  = 1'b0;
                end
                st = i;
            end
            prev = ws_q[i];
        end
    endtask

    task automatic drive(input int h, input int from, input int to);
        for (int i = from; i < to; i++) begin
            bus.sck = 1'b0;
            bus.ws  = ws_q[i];
            bus.sd  = sd_q[i];
            repeat (h) @(negedge clk);
            bus.sck = 1'b1;
            repeat (h) @(negedge clk);
        end
        bus.sck = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_left"}, bus.data_left, '0);
        chk({tag, "_right"}, bus.data_right, '0);
        chk({tag, "_valid"}, bus.data_valid, 1'b0);
        chk({tag, "_state"}, dut.state_q, 1'b0);
`ifdef I2S_RCVR_FRAME_ERR_EN
        chk({tag, "_ferr"}, bus.frame_err, 1'b0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sck = 1'b0;
        bus.ws  = 1'b0;
        bus.sd  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_run();
        run_model();
        n_valid = 0;
        mon_en  = 1'b1;
    endtask

    task automatic finish_run(input string tag);
        repeat (12) @(negedge clk);
        mon_en = 1'b0;
        chk({tag, "_nvalid"}, n_valid, exp_nv);
        chk({tag, "_left"}, bus.data_left, exp_left);
        chk({tag, "_right"}, bus.data_right, exp_right);
        chk({tag, "_pending"}, exp_l_q.size(), 0);
`ifdef I2S_RCVR_FRAME_ERR_EN
        chk({tag, "_ferr"}, bus.frame_err, exp_ferr);
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && bus.data_valid) begin
            chk("dv_pulse", dv_prev, 1'b0);
            n_valid++;
            if (exp_l_q.size() == 0) begin
                chk("unexp_valid", 1'b1, 1'b0);
            end else begin
                chk("pair_left", bus.data_left, exp_l_q.pop_front());
                chk("pair_right", bus.data_right, exp_r_q.pop_front());
            end
        end
        dv_prev = bus.data_valid;
    end

    int split;

    initial begin
        bus.sck = 1'b0;
        bus.ws  = 1'b0;
        bus.sd  = 1'b0;

        // Reset in the middle of a stream
        do_reset();
        new_stream();
        add_frames(4, W);
        end_stream();
        drive(4, 0, 80);
        #3 rst = 1'b1;
        #1 check_reset("async");
        repeat (2) @(negedge clk);

        // Nominal 16-bit slots at 8x oversampling
        do_reset();
        new_stream();
        for (int f = 0; f < 4; f++) begin
            add_slot(1'b0, W, 64'hA5C3);
            add_slot(1'b1, W, 64'h1234);
        end
        end_stream();
        start_run();
        drive(4, 0, ws_q.size());
        finish_run("nom");
        chk("nom_left_k", bus.data_left, 16'hA5C3);
        chk("nom_right_k", bus.data_right, 16'h1234);

        // Start inside a right slot
        do_reset();
        new_stream();
        add_slot(1'b1, W, {$urandom, $urandom});
        for (int k = 0; k < 7; k++) begin
            void'(ws_q.pop_front());
            void'(sd_q.pop_front());
        end
        add_frames(3, W);
        end_stream();
        start_run();
        drive(4, 0, ws_q.size());
        finish_run("mid");

        // 32-bit slots truncate to the top 16 bits
        do_reset();
        new_stream();
        add_slot(1'b0, 32, 64'hDEADBEEF);
        add_slot(1'b1, 32, {$urandom, $urandom});
        add_slot(1'b0, 32, 64'hDEADBEEF);
        add_slot(1'b1, 32, {$urandom, $urandom});
        end_stream();
        start_run();
        drive(4, 0, ws_q.size());
        finish_run("s32");
        chk("s32_left_k", bus.data_left, 16'hDEAD);
`ifdef I2S_RCVR_FRAME_ERR_EN
        chk("s32_ferr_k", bus.frame_err, 1'b1);
`endif

        // 12-bit slots, then good frames; frame_err must stay set
        do_reset();
        new_stream();
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 12, {$urandom, $urandom});
            add_slot(1'b1, 12, 64'hABC);
        end
        split = ws_q.size() + 1;
        add_frames(2, W);
        end_stream();
        start_run();
        drive(4, 0, split);
        repeat (12) @(negedge clk);
        chk("s12_right_k", bus.data_right, 16'hABC0);
`ifdef I2S_RCVR_FRAME_ERR_EN
        chk("s12_ferr_k", bus.frame_err, 1'b1);
`endif
        drive(4, split, ws_q.size());
        finish_run("s12");
`ifdef I2S_RCVR_FRAME_ERR_EN
        chk("s12_ferr_sticky", bus.frame_err, 1'b1);
`endif

        // Back-to-back random frames at 4x oversampling
        do_reset();
        new_stream();
        add_frames(20, W);
        end_stream();
        start_run();
        drive(2, 0, ws_q.size());
        finish_run("b2b");

        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
